// File: rtl/sd_image_loader.sv
// sd_image_loader: copies SECTOR_COUNT sectors from the SD-SPI reader into RAM as little-endian words.
// Latency: a word is queued the cycle its 4th byte arrives; mem_we asserts 1 cycle after the queue is non-empty.
// Backpressure: mem_ready stalls the drain only; the reader cannot be stalled, so a push into a full FIFO aborts (error).
// Ports: clk/rstn; start; reader side rstart/rsector/rbusy/rdone/outen/outaddr/outbyte;
//        RAM side mem_we/mem_addr/mem_wdata/mem_ready; status busy/done/error/sectors_done.

module sd_image_loader_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

module sd_image_loader #(
  parameter logic [31:0] START_SECTOR = 32'd2048,
  parameter logic [31:0] SECTOR_COUNT = 32'd16384,
  parameter logic [31:0] RAM_BASE     = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        rstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] sectors_done
);
  typedef enum logic [2:0] {IDLE, REQ, RECV, FLUSH, FIN, ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] rsector_q, rsector_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] sectors_done_q, sectors_done_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;   // 0..512, one past the last byte of a sector
  logic [23:0] pack_q, pack_d;           // byte lanes 0..2; lane 3 goes straight into the pushed word

  logic        fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic [31:0] fifo_dout, push_word;
  logic        byte_ok;

  assign push_word = {outbyte, pack_q};
  assign byte_ok   = ({1'b0, outaddr} == byte_cnt_q);

  sd_image_loader_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (push_word),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d        = state_q;
    rsector_d      = rsector_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_we_d       = mem_we_q;
    sectors_done_d = sectors_done_q;
    byte_cnt_d     = byte_cnt_q;
    pack_d         = pack_q;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_clr       = 1'b0;

    // RAM drain: the head word stays in the FIFO until the RAM takes it,
    // so the in-flight write still counts toward FIFO occupancy.
    if (state_q != IDLE && state_q != ERR) begin
      if (mem_we_q) begin
        if (mem_ready) begin
          fifo_pop   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = mem_addr_q + 32'd4;
        end
      end else if (!fifo_empty) begin
        mem_we_d    = 1'b1;
        mem_wdata_d = fifo_dout;
      end
    end

    case (state_q)
      IDLE, FIN, ERR: begin
        if (start) begin
          state_d        = REQ;
          rsector_d      = START_SECTOR;
          mem_addr_d     = RAM_BASE;
          mem_we_d       = 1'b0;
          sectors_done_d = '0;
          byte_cnt_d     = '0;
          pack_d         = '0;
          fifo_clr       = 1'b1;
        end
      end
      REQ: begin
        if (rbusy) state_d = RECV;
      end
      RECV: begin
        if (outen) begin
          if (!byte_ok) begin
            state_d = ERR;
          end else begin
            byte_cnt_d = byte_cnt_q + 10'd1;
            case (outaddr[1:0])
              2'd0: pack_d[7:0]   = outbyte;
              2'd1: pack_d[15:8]  = outbyte;
              2'd2: pack_d[23:16] = outbyte;
              default: begin
                if (fifo_full) state_d = ERR;
                else           fifo_push = 1'b1;
              end
            endcase
          end
        end
        // The byte of this cycle is already folded into byte_cnt_d.
        if (rdone && state_d != ERR) begin
          if (byte_cnt_d != 10'd512) begin
            state_d = ERR;
          end else begin
            sectors_done_d = sectors_done_q + 32'd1;
            if (sectors_done_q + 32'd1 == SECTOR_COUNT) begin
              state_d = FLUSH;
            end else begin
              rsector_d  = rsector_q + 32'd1;
              byte_cnt_d = '0;
              state_d    = REQ;
            end
          end
        end
      end
      FLUSH: begin
        if (fifo_empty && !mem_we_q) state_d = FIN;
      end
      default: ;
    endcase

    // Abort drops the queued words and any write the RAM has not yet taken.
    if (state_d == ERR) begin
      mem_we_d  = 1'b0;
      fifo_clr  = 1'b1;
      fifo_push = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      rsector_q      <= START_SECTOR;
      mem_addr_q     <= RAM_BASE;
      mem_wdata_q    <= '0;
      mem_we_q       <= 1'b0;
      sectors_done_q <= '0;
      byte_cnt_q     <= '0;
      pack_q         <= '0;
    end else begin
      state_q        <= state_d;
      rsector_q      <= rsector_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_we_q       <= mem_we_d;
      sectors_done_q <= sectors_done_d;
      byte_cnt_q     <= byte_cnt_d;
      pack_q         <= pack_d;
    end
  end

  assign rstart       = (state_q == REQ);
  assign rsector      = rsector_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q == REQ) || (state_q == RECV) || (state_q == FLUSH);
  assign done         = (state_q == FIN);
  assign error        = (state_q == ERR);
  assign sectors_done = sectors_done_q;
endmodule

// File: tb/tb_sd_image_loader.sv
module tb_sd_image_loader;
  localparam logic [31:0] A_START = 32'd5;
  localparam logic [31:0] A_BASE  = 32'hFFFF_FF00;
  localparam logic [31:0] B_START = 32'd2048;
  localparam logic [31:0] B_BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0, sel = 1'b0;
  logic rbusy = 1'b0, rdone = 1'b0, outen = 1'b0, mem_ready = 1'b0;
  logic [8:0] outaddr = '0;
  logic [7:0] outbyte = '0;
  logic start_a, start_b;

  logic a_rstart, a_mem_we, a_busy, a_done, a_error;
  logic [31:0] a_rsector, a_mem_addr, a_mem_wdata, a_sectors_done;
  logic b_rstart, b_mem_we, b_busy, b_done, b_error;
  logic [31:0] b_rsector, b_mem_addr, b_mem_wdata, b_sectors_done;
  logic o_rstart, o_mem_we, o_busy, o_done, o_error;
  logic [31:0] o_rsector, o_mem_addr, o_mem_wdata, o_sectors_done;

  always #5 clk = ~clk;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  sd_image_loader #(.START_SECTOR(A_START), .SECTOR_COUNT(32'd1), .RAM_BASE(A_BASE), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .rstart(a_rstart), .rsector(a_rsector),
    .rbusy(rbusy), .rdone(rdone), .outen(outen), .outaddr(outaddr), .outbyte(outbyte),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_ready(mem_ready),
    .busy(a_busy), .done(a_done), .error(a_error), .sectors_done(a_sectors_done));

  sd_image_loader #(.START_SECTOR(B_START), .SECTOR_COUNT(32'd3), .RAM_BASE(B_BASE), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .rstart(b_rstart), .rsector(b_rsector),
    .rbusy(rbusy), .rdone(rdone), .outen(outen), .outaddr(outaddr), .outbyte(outbyte),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_ready(mem_ready),
    .busy(b_busy), .done(b_done), .error(b_error), .sectors_done(b_sectors_done));

  always_comb begin
    o_rstart       = sel ? b_rstart       : a_rstart;
    o_rsector      = sel ? b_rsector      : a_rsector;
    o_mem_we       = sel ? b_mem_we       : a_mem_we;
    o_mem_addr     = sel ? b_mem_addr     : a_mem_addr;
    o_mem_wdata    = sel ? b_mem_wdata    : a_mem_wdata;
    o_busy         = sel ? b_busy         : a_busy;
    o_done         = sel ? b_done         : a_done;
    o_error        = sel ? b_error        : a_error;
    o_sectors_done = sel ? b_sectors_done : a_sectors_done;
  end

  int n_tests = 0, n_fail = 0;
  int ready_mode = 0;       // 0: always ready, 1: random 50%, 2: never ready
  bit mon_en = 1'b0;

  // Reference model: byte stream -> ordered queue of {addr, word}
  logic [63:0] exp_q[$];
  int          mdl_cnt;
  logic [31:0] mdl_word, mdl_addr;

  int ncyc = 0, last_acc = 0, acc_cnt = 0;
  logic prev_we = 1'b0, prev_rdy = 1'b0;
  logic [31:0] prev_addr, prev_data, first_addr, first_data, last_addr, last_data;
  logic [63:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic void mdl_reset(input logic [31:0] base);
    exp_q.delete();
    mdl_cnt  = 0;
    mdl_word = '0;
    mdl_addr = base;
    acc_cnt  = 0;
  endfunction

  function automatic void mdl_byte(input logic [7:0] b);
    mdl_word[8*(mdl_cnt%4) +: 8] = b;
    if (mdl_cnt % 4 == 3) begin
      exp_q.push_back({mdl_addr, mdl_word});
      mdl_addr = mdl_addr + 32'd4;
    end
    mdl_cnt++;
  endfunction

  always @(posedge clk) ncyc <= ncyc + 1;

  initial forever begin
    @(posedge clk); #1;
    mem_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Write monitor: every accepted RAM write must be the next model word; unaccepted writes must hold.
  always @(negedge clk) begin
    if (mon_en && rstn) begin
      if (prev_we && !prev_rdy) begin
        chk("we_hold", 32'(o_mem_we), 32'd1);
        chk("addr_hold", o_mem_addr, prev_addr);
        chk("data_hold", o_mem_wdata, prev_data);
      end
      if (o_mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_write: got write addr 0x%08h data 0x%08h, required none", o_mem_addr, o_mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", o_mem_addr, mon_e[63:32]);
          chk("wr_data", o_mem_wdata, mon_e[31:0]);
        end
        if (acc_cnt == 0) begin first_addr = o_mem_addr; first_data = o_mem_wdata; end
        last_addr = o_mem_addr; last_data = o_mem_wdata;
        acc_cnt++;
        last_acc = ncyc;
      end
      prev_we = o_mem_we; prev_rdy = mem_ready; prev_addr = o_mem_addr; prev_data = o_mem_wdata;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rstart", 32'(o_rstart), 32'd0);
    chk("rst_rsector", o_rsector, sel ? B_START : A_START);
    chk("rst_mem_we", 32'(o_mem_we), 32'd0);
    chk("rst_mem_addr", o_mem_addr, sel ? B_BASE : A_BASE);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_sectors_done", o_sectors_done, 32'd0);
  endtask

  task automatic handshake(input logic [31:0] exp_sec, output bit ok);
    int t;
    t = 0;
    ok = 1'b0;
    while (o_rstart !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (o_rstart !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL rstart_timeout: got rstart 0, required 1 within 100 cycles");
      return;
    end
    chk("rsector_req", o_rsector, exp_sec);
    repeat ($urandom_range(0, 2)) tick();
    tick(); rbusy = 1'b1;
    tick();
    chk("rstart_drop", 32'(o_rstart), 32'd0);
    ok = 1'b1;
  endtask

  task automatic send_byte(input int k);
    tick(); outen = 1'b1; outaddr = 9'(k); outbyte = 8'(k);
  endtask

  // One sector from the reader. abort_at >= 0 drops rstn before that byte.
  task automatic run_sector(input logic [31:0] exp_sec, input bit rnd, input int gap_max,
                            input int abort_at, input int start_at, input bit last);
    bit ok;
    bit same;
    logic [7:0] b;
    handshake(exp_sec, ok);
    if (!ok) return;
    same = last ? 1'b1 : 1'($urandom_range(0, 1));
    for (int k = 0; k < 512; k++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin tick(); outen = 1'b0; start = 1'b0; end
      tick();
      if (k == abort_at) begin
        outen = 1'b0; start = 1'b0; mon_en = 1'b0; rstn = 1'b0;
        #1;
        chk_reset_vals();
        return;
      end
      b = rnd ? 8'($urandom) : 8'(k);
      outen = 1'b1; outaddr = 9'(k); outbyte = b;
      mdl_byte(b);
      start = (k == start_at);
      rdone = (k == 511) && same;
      if (rdone) begin
        chk("rstart_at_rdone", 32'(o_rstart), 32'd0);
        chk("rsector_at_rdone", o_rsector, exp_sec);
      end
    end
    tick(); outen = 1'b0; rdone = 1'b0; start = 1'b0;
    if (!same) begin
      repeat ($urandom_range(0, 2)) tick();
      rdone = 1'b1;
      chk("rstart_at_rdone", 32'(o_rstart), 32'd0);
      chk("rsector_at_rdone", o_rsector, exp_sec);
      tick(); rdone = 1'b0;
    end
    rbusy = 1'b0;
  endtask

  task automatic wait_done(input int n_words, input logic [31:0] n_sec);
    int t;
    t = 0;
    while (o_done !== 1'b1 && o_error !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    chk("done", 32'(o_done), 32'd1);
    chk("done_latency", 32'(ncyc), 32'(last_acc + 2));
    chk("write_count", 32'(acc_cnt), 32'(n_words));
    chk("writes_missing", 32'(exp_q.size()), 32'd0);
    chk("sectors_done", o_sectors_done, n_sec);
    chk("busy_at_done", 32'(o_busy), 32'd0);
    chk("error_at_done", 32'(o_error), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1; chk_reset_vals();
    sel = 1'b1; #1; chk_reset_vals();
    @(negedge clk); rstn = 1'b1;

    // Single sector, sector 5, bytes k%256, RAM always ready; base wraps past 2^32.
    sel = 1'b0; ready_mode = 0; tick();
    mdl_reset(A_BASE); mon_en = 1'b1;
    pulse_start();
    chk("busy_after_start", 32'(o_busy), 32'd1);
    run_sector(A_START, 1'b0, 0, -1, 200, 1'b1);
    wait_done(128, 32'd1);
    chk("first_addr", first_addr, 32'hFFFF_FF00);
    chk("first_data", first_data, 32'h0302_0100);
    chk("last_addr", last_addr, 32'h0000_00FC);
    chk("last_data", last_data, 32'hFFFE_FDFC);

    // Restart after done clears the status and copies again.
    mdl_reset(A_BASE);
    pulse_start();
    chk("restart_sectors_done", o_sectors_done, 32'd0);
    chk("restart_done", 32'(o_done), 32'd0);
    chk("restart_busy", 32'(o_busy), 32'd1);
    run_sector(A_START, 1'b1, 1, -1, 300, 1'b1);
    wait_done(128, 32'd1);

    // Three sectors, random data, RAM ready 50%.
    sel = 1'b1; ready_mode = 1;
    mdl_reset(B_BASE);
    pulse_start();
    for (int s = 0; s < 3; s++) run_sector(B_START + 32'(s), 1'b1, 3, -1, -1, s == 2);
    wait_done(384, 32'd3);

    // Overflow: RAM never ready, the fifth completed word aborts.
    mon_en = 1'b0; ready_mode = 2; tick();
    pulse_start();
    handshake(B_START, ok);
    for (int k = 0; k < 19; k++) send_byte(k);
    tick(); outen = 1'b0;
    @(negedge clk);
    chk("ovf_error_before", 32'(o_error), 32'd0);
    chk("ovf_we_pending", 32'(o_mem_we), 32'd1);
    send_byte(19);
    tick(); outen = 1'b0;
    @(negedge clk);
    chk("ovf_error", 32'(o_error), 32'd1);
    chk("ovf_mem_we", 32'(o_mem_we), 32'd0);
    chk("ovf_busy", 32'(o_busy), 32'd0);
    chk("ovf_rstart", 32'(o_rstart), 32'd0);
    rbusy = 1'b0;

    // Reader skips byte 37.
    ready_mode = 0;
    pulse_start();
    handshake(B_START, ok);
    for (int k = 0; k < 37; k++) send_byte(k);
    tick(); outen = 1'b0;
    @(negedge clk);
    chk("skip_error_before", 32'(o_error), 32'd0);
    send_byte(38);
    tick(); outen = 1'b0;
    @(negedge clk);
    chk("skip_error", 32'(o_error), 32'd1);
    rbusy = 1'b0;

    // rdone after only 511 bytes.
    pulse_start();
    handshake(B_START, ok);
    for (int k = 0; k < 511; k++) send_byte(k);
    tick(); outen = 1'b0;
    @(negedge clk);
    chk("short_error_before", 32'(o_error), 32'd0);
    tick(); rdone = 1'b1;
    tick(); rdone = 1'b0;
    @(negedge clk);
    chk("short_error", 32'(o_error), 32'd1);
    chk("short_sectors_done", o_sectors_done, 32'd0);
    rbusy = 1'b0;

    // Reset during sector 2, byte 100, then a clean full copy.
    ready_mode = 1;
    mdl_reset(B_BASE); mon_en = 1'b1;
    pulse_start();
    run_sector(B_START, 1'b1, 2, -1, -1, 1'b0);
    run_sector(B_START + 32'd1, 1'b1, 2, 100, -1, 1'b0);
    rbusy = 1'b0;
    @(negedge clk); rstn = 1'b1;
    mdl_reset(B_BASE); mon_en = 1'b1;
    pulse_start();
    for (int s = 0; s < 3; s++) run_sector(B_START + 32'(s), 1'b1, 2, -1, -1, s == 2);
    wait_done(384, 32'd3);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_image_loader.md
Name: sd_image_loader

Overview:
- Boot-time copy engine sitting directly downstream of the SD-SPI sector reader.
- Issues consecutive sector-read commands to the reader and packs the returned byte stream into little-endian 32-bit words.
- Writes the words to system RAM through a simple valid/ready write port.
- Copies SECTOR_COUNT sectors starting at START_SECTOR to RAM_BASE, then reports done, or reports error on a protocol violation.

Parameters:
- START_SECTOR, 2048: first SD sector (LBA) to read.
- SECTOR_COUNT, 16384: number of 512-byte sectors to copy; must be at least 1.
- RAM_BASE, 32'h8000_0000: byte address of the first RAM word written; must be 4-byte aligned.
- FIFO_DEPTH, 4: word FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a copy.
- rstart  out  1  sector read request to the reader (level).
- rsector  out  32  sector number for the current request.
- rbusy  in  1  reader busy flag.
- rdone  in  1  reader one-cycle pulse: sector finished.
- outen  in  1  byte strobe from the reader.
- outaddr  in  9  byte offset within the sector, 0..511.
- outbyte  in  8  sector data byte.
- mem_we  out  1  RAM write valid.
- mem_addr  out  32  RAM byte address, word aligned.
- mem_wdata  out  32  RAM write data.
- mem_ready  in  1  RAM accepts the write in any cycle where mem_we and mem_ready are both 1.
- busy  out  1  copy in progress.
- done  out  1  sticky: copy complete.
- error  out  1  sticky: copy aborted.
- sectors_done  out  32  count of fully received sectors.

Behaviour:
- Reset values: rstart=0, rsector=START_SECTOR, mem_we=0, mem_addr=RAM_BASE, mem_wdata=0, busy=0, done=0, error=0, sectors_done=0. FIFO is empty, the packer is cleared and the FSM is in IDLE. Reset takes effect in any state, including mid-sector; no partial word is written afterwards.
- FSM states: IDLE, REQ, RECV, FLUSH, FIN, ERR.
- IDLE
  - On start, go to REQ, set busy=1 and clear done, error and sectors_done.
  - Load rsector=START_SECTOR and mem_addr=RAM_BASE; clear the byte counter.
- REQ
  - Hold rstart=1 with rsector stable.
  - On the first cycle rbusy=1 is sampled, drop rstart the next cycle and go to RECV.
  - rstart must be 0 before rdone can occur, so the reader cannot re-trigger on the same request.
- RECV
  - rsector stays stable.
  - Each outen byte goes into lane outaddr[1:0] of the packing register, with byte 0 at bits [7:0].
  - When outaddr[1:0]==3, push the completed word into the FIFO in the same cycle.
  - Expected-address check: outaddr must equal the internal byte counter, which runs 0..511 per sector. A mismatch goes to ERR.
  - On rdone:
    - Byte counter must be 512; otherwise go to ERR.
    - sectors_done increments.
    - If sectors_done+1 == SECTOR_COUNT, go to FLUSH.
    - Otherwise rsector increments, the byte counter clears, and the FSM goes to REQ on the next cycle.
  - outen and rdone in the same cycle: the byte is processed first, then the rdone check applies.
  - Overflow: a word push while the FIFO is full goes to ERR. The reader has no backpressure, so this is fatal; the word is dropped.
- RAM drain runs in every state except IDLE and ERR, concurrently with RECV:
  - When the FIFO is non-empty and mem_we=0, assert mem_we with the head word.
  - Hold mem_we, mem_addr and mem_wdata stable until mem_ready is sampled 1.
  - On acceptance, pop the FIFO and add 4 to mem_addr. mem_we may reassert on the next cycle.
  - Push and pop in the same cycle keep the FIFO occupancy unchanged.
  - mem_addr wraps modulo 2^32 with no error.
- FLUSH: when the FIFO is empty and mem_we=0, go to FIN.
- FIN: done=1 and busy=0. A new start restarts exactly as from IDLE.
- ERR
  - error=1, busy=0, rstart=0, mem_we=0.
  - The FIFO is discarded, including any write left unaccepted.
  - A new start restarts exactly as from IDLE.
- start while busy=1 is ignored.
- Latency: the last RAM write is issued no earlier than 1 cycle after the final rdone. done rises 1 cycle after the last mem_ready acceptance.

Test Plan:
- Single sector: SECTOR_COUNT=1, START_SECTOR=5, reader model bytes k%256, mem_ready=1.
  - Required: rsector=5 while rstart=1.
  - 128 writes; first write 32'h03020100 to RAM_BASE; last write 32'hFFFEFDFC to RAM_BASE+0x1FC.
  - done=1, sectors_done=1.
- Three sectors with mem_ready randomly low 50%: SECTOR_COUNT=3.
  - Required: rsector sequence 2048, 2049, 2050; rstart=0 before each rdone.
  - 384 ordered writes with no gaps or duplicates; done only after the last acceptance.
- Backpressure overflow: mem_ready=0 for the whole sector, FIFO_DEPTH=4.
  - Required: the fifth completed word raises error=1, then mem_we=0 and busy=0.
- Protocol errors:
  - Reader skips outaddr 37: error=1 on that byte.
  - Separate run with rdone after 511 bytes: error=1.
- Reset mid-copy: assert rstn low during sector 2, byte 100.
  - Required: all outputs at their reset values immediately.
  - After a new start, the copy begins again at START_SECTOR and RAM_BASE and completes normally.
- start pulse while busy ignored, with no sequence change; start after done restarts with sectors_done cleared to 0.
